// File: rtl/conv_enc_frame_ctrl.sv
// Frame controller around a K=3 (7,5) convolutional encoder: takes info bits, appends a zero
// tail, optionally punctures to rate 3/4, and streams coded bits out one per handshake.
module conv_enc_frame_ctrl #(
    parameter int LEN_W     = 12,
    parameter int TAIL_BITS = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             rate_sel,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fsm_state
);

    // Handshakes: a transfer happens on a rising CLK edge where valid && ready are both high;
    // out_bit/out_last hold while out_valid && !out_ready, and the source holds in_bit likewise.

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

    localparam logic [LEN_W-1:0] TAIL_LAST = LEN_W'(TAIL_BITS - 1);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic             rate_q;
    logic [LEN_W-1:0] cnt;
    logic [1:0]       enc;        // {s1, s0}
    logic [1:0]       phase;
    logic [1:0]       pend;       // head of the pending queue is bit 0
    logic [1:0]       pend_cnt;
    logic             last_q;
    logic             done_q;

    logic             step_en;
    logic             step_bit;
    logic             g0, g1;
    logic [1:0]       load_bits;
    logic [1:0]       load_cnt;
    logic             out_hs;

    always_comb begin
        state_nxt = state;
        step_en   = 1'b0;
        step_bit  = 1'b0;
        out_hs    = (pend_cnt != 2'd0) && out_ready;
        case (state)
            IDLE: begin
                if (start && (frame_len != '0)) state_nxt = DATA;
            end
            DATA: begin
                if (in_valid && (pend_cnt == 2'd0)) begin
                    step_en  = 1'b1;
                    step_bit = in_bit;
                    if (cnt == len_q - 1'b1) state_nxt = TAIL;
                end
            end
            TAIL: begin
                if (pend_cnt == 2'd0) begin
                    step_en = 1'b1;
                    if (cnt == TAIL_LAST) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && (pend_cnt == 2'd1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        g0 = step_bit ^ enc[0] ^ enc[1];
        g1 = step_bit ^ enc[1];

        // Puncturing pattern for rate 3/4 over phases 0,1,2: {g0,g1}, {g0}, {g1}
        load_bits = {g1, g0};
        load_cnt  = 2'd2;
        if (rate_q && (phase == 2'd1)) begin
            load_bits = {1'b0, g0};
            load_cnt  = 2'd1;
        end else if (rate_q && (phase == 2'd2)) begin
            load_bits = {1'b0, g1};
            load_cnt  = 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            len_q    <= '0;
            rate_q   <= 1'b0;
            cnt      <= '0;
            enc      <= 2'b00;
            phase    <= 2'd0;
            pend     <= 2'b00;
            pend_cnt <= 2'd0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == DRAIN) && (state_nxt == IDLE);

            if ((state == IDLE) && (state_nxt == DATA)) begin
                len_q  <= frame_len;
                rate_q <= rate_sel;
                cnt    <= '0;
                enc    <= 2'b00;
                phase  <= 2'd0;
                last_q <= 1'b0;
            end

            if (step_en) begin
                pend     <= load_bits;
                pend_cnt <= load_cnt;
                enc      <= {enc[0], step_bit};
                phase    <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                cnt      <= (state_nxt != state) ? '0 : cnt + 1'b1;
                if ((state == TAIL) && (state_nxt == DRAIN)) last_q <= 1'b1;
            end else if (out_hs) begin
                pend     <= {1'b0, pend[1]};
                pend_cnt <= pend_cnt - 2'd1;
            end

            if ((state == DRAIN) && (state_nxt == IDLE)) begin
                enc    <= 2'b00;
                last_q <= 1'b0;
            end
        end
    end

    assign in_ready  = (state == DATA) && (pend_cnt == 2'd0);
    assign out_valid = (pend_cnt != 2'd0);
    assign out_bit   = pend[0];
    assign out_last  = last_q && (pend_cnt == 2'd1);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Directed bench for conv_enc_frame_ctrl: table of frames with hand-computed coded streams,
// plus reset-abort and ignored-start sequences.
module tb_conv_enc_frame_ctrl;

    localparam int LEN_W = 12;

    logic             CLK = 1'b0;
    logic             RST;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             rate_sel;
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [1:0]       fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [0:0] exp_q[$];

    typedef struct {
        logic        rate;
        int          len;
        logic [15:0] inb;     // first info bit at [len-1]
        int          n;
        logic [63:0] exp;     // first coded bit at [n-1]
        bit          stall;
        bit          mid_start;
    } vec_t;

    vec_t vecs[8];

    conv_enc_frame_ctrl #(.LEN_W(LEN_W), .TAIL_BITS(2)) dut (
        .CLK(CLK), .RST(RST), .start(start), .frame_len(frame_len), .rate_sel(rate_sel),
        .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
        .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int   in_idx   = 0;
        int   out_idx  = 0;
        int   viol     = 0;
        int   bit_bad  = 0;
        int   last_bad = 0;
        bit   finished = 0;
        logic held_valid = 1'b0;
        logic held_bit   = 1'b0;
        logic held_last  = 1'b0;
        logic [0:0] e;

        exp_q.delete();
        for (int i = 0; i < v.n; i++) exp_q.push_back(v.exp[v.n-1-i]);

        @(negedge CLK);
        start     = 1'b1;
        frame_len = v.len[LEN_W-1:0];
        rate_sel  = v.rate;
        @(negedge CLK);
        start     = 1'b0;
        frame_len = LEN_W'($urandom);
        rate_sel  = ~v.rate;
        check($sformatf("busy_after_start[%0d]", idx), {63'd0, busy}, 64'd1);

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (held_valid && (!out_valid || out_bit !== held_bit || out_last !== held_last)) viol++;
            if (in_ready && out_valid) viol++;
            if (!busy || done) viol++;

            in_valid  = (in_idx < v.len) && (!v.stall || $urandom_range(0, 3) != 0);
            in_bit    = (in_idx < v.len) ? v.inb[v.len-1-in_idx] : 1'b0;
            out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = v.mid_start && (cyc == 3);
            if (start) frame_len = LEN_W'(1);

            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                if (out_bit !== e[0]) begin
                    bit_bad++;
                    $display("FAIL frame%0d_bit%0d: got %0b, expected %0b", idx, out_idx, out_bit, e[0]);
                end
                if (out_last !== (out_idx == v.n - 1)) last_bad++;
                out_idx++;
                if (out_idx == v.n) finished = 1;
            end
            held_valid = out_valid && !out_ready;
            held_bit   = out_bit;
            held_last  = out_last;
            if (in_valid && in_ready) in_idx++;
            @(negedge CLK);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        check($sformatf("frame%0d_finished", idx), {63'd0, finished}, 64'd1);
        check($sformatf("frame%0d_bits_wrong", idx), 64'(bit_bad), 64'd0);
        check($sformatf("frame%0d_last_wrong", idx), 64'(last_bad), 64'd0);
        check($sformatf("frame%0d_inputs_taken", idx), 64'(in_idx), 64'(v.len));
        check($sformatf("frame%0d_protocol", idx), 64'(viol), 64'd0);
        check($sformatf("frame%0d_done_busy", idx), {62'd0, done, busy}, 64'b10);
        @(negedge CLK);
        check($sformatf("frame%0d_done_clear", idx), {62'd0, done, out_valid}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1, 16'b1,    6,  64'b111011,       1'b0, 1'b0};
        vecs[1] = '{1'b0, 4, 16'b1011, 12, 64'b111000010111, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1, 16'b1,    4,  64'b1111,         1'b0, 1'b0};
        vecs[3] = '{1'b0, 4, 16'b1011, 12, 64'b111000010111, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 4, 16'b1011, 8,  64'b11100101,     1'b0, 1'b0};
        vecs[5] = '{1'b1, 2, 16'b11,   6,  64'b110111,       1'b0, 1'b0};
        vecs[6] = '{1'b0, 3, 16'b000,  10, 64'b0,            1'b0, 1'b0};
        vecs[7] = '{1'b1, 4, 16'b1011, 8,  64'b11100101,     1'b1, 1'b1};

        RST = 1'b1; start = 1'b0; frame_len = '0; rate_sel = 1'b0;
        in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {56'd0, in_ready, out_valid, out_bit, out_last, busy, done, fsm_state}, 64'd0);
        RST = 1'b0;

        // zero-length start is ignored
        @(negedge CLK);
        start = 1'b1; frame_len = '0; rate_sel = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("zero_len_start", {61'd0, busy, in_ready, out_valid}, 64'd0);

        for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

        // reset after the second info bit of a rate-1/2 frame aborts it
        begin
            int acc = 0;
            logic [3:0] bits = 4'b1011;
            @(negedge CLK);
            start = 1'b1; frame_len = LEN_W'(4); rate_sel = 1'b0;
            @(negedge CLK);
            start = 1'b0; out_ready = 1'b1;
            for (int cyc = 0; cyc < 50 && acc < 2; cyc++) begin
                in_valid = 1'b1;
                in_bit   = bits[3-acc];
                if (in_ready) acc++;
                @(negedge CLK);
            end
            in_valid = 1'b0;
            check("abort_reached_2_bits", 64'(acc), 64'd2);
            RST = 1'b1;
            @(negedge CLK);
            check("abort_outputs", {56'd0, in_ready, out_valid, out_bit, out_last, busy, done, fsm_state}, 64'd0);
            RST = 1'b0; out_ready = 1'b0;
            @(negedge CLK);
            check("abort_no_done", {62'd0, done, busy}, 64'd0);
        end
        run_frame(vecs[0], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
